// File: rtl/frame_buffer_port_arbiter_pkg.sv
// Shared definitions for the frame-buffer port arbiter: one-hot FSM encoding,
// default widths and the buffer-index (address MSB) selection helper.
package frame_buffer_port_arbiter_pkg;

    localparam int FB_ADDR_W_DEFAULT = 16;
    localparam int FB_DATA_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ARB_IDLE = 3'b001,
        ARB_DISP = 3'b010,
        ARB_RAST = 3'b100
    } arb_state_e;

    // Display scans the front buffer (the one the rasterizer is not targeting).
    function automatic logic buf_index(input logic target, input logic is_display);
        return is_display ? ~target : target;
    endfunction

endpackage

// File: rtl/fb_rd_valid_pipe.sv
// Read-issue tracker: shifts the display grant flag down a DEPTH-stage pipe so
// the last stage lines up with SRAM read data.
module fb_rd_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_issue,
    output logic o_valid,
    output logic o_pending
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    // Next pipe contents: shift in this cycle's read grant.
    always_comb begin
        pipe_d = {pipe_q[DEPTH-2:0], i_issue};
    end

    // Pipe register; reset drops every read still in flight.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            pipe_q <= {DEPTH{1'b0}};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign o_valid   = pipe_q[DEPTH-1];
    // Reads that will still be outstanding once the last stage retires.
    assign o_pending = |pipe_q[DEPTH-2:0];

endmodule

// File: rtl/frame_buffer_port_arbiter.sv
// Single-port frame-buffer SRAM arbiter: display reads (priority, streak-limited)
// versus rasterizer writes. Optional stall counter enabled by FB_ARB_STATS_EN.
module frame_buffer_port_arbiter
    import frame_buffer_port_arbiter_pkg::*;
#(
    parameter int ADDR_W          = FB_ADDR_W_DEFAULT,
    parameter int DATA_W          = FB_DATA_W_DEFAULT,
    parameter int READ_LATENCY    = 1,
    parameter int DISP_MAX_STREAK = 8
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic              i_rasterization_target,
    input  logic              i_vblank,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic              o_disp_gnt,
    output logic [DATA_W-1:0] o_disp_rdata,
    output logic              o_disp_rvalid,
    input  logic              i_rast_req,
    input  logic [ADDR_W-1:0] i_rast_addr,
    input  logic [DATA_W-1:0] i_rast_wdata,
    output logic              o_rast_gnt,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W:0]   o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_frame_buffer_swap_allowed
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]       o_rast_stall_count
`endif
);

    localparam int STREAK_W = $clog2(DISP_MAX_STREAK + 1);

    arb_state_e          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                swap_q, swap_d;
    logic                disp_gnt_s, rast_gnt_s, streak_full_s;
    logic                rd_valid_s, rd_pending_s;

    // Grant decision, FSM next state and display streak tracking.
    always_comb begin
        // A non-zero streak can only follow a display grant, so gate on DISP.
        streak_full_s = (state_q == ARB_DISP) && (streak_q == STREAK_W'(DISP_MAX_STREAK));
        disp_gnt_s    = 1'b0;
        rast_gnt_s    = 1'b0;
        state_d       = ARB_IDLE;
        if (i_srst) begin
            state_d = ARB_IDLE;
        end else if (i_disp_req && !(i_rast_req && streak_full_s)) begin
            disp_gnt_s = 1'b1;
            state_d    = ARB_DISP;
        end else if (i_rast_req) begin
            rast_gnt_s = 1'b1;
            state_d    = ARB_RAST;
        end else begin
            state_d = ARB_IDLE;
        end

        if (rast_gnt_s || !i_rast_req) begin
            streak_d = STREAK_W'(0);
        end else if (disp_gnt_s && !streak_full_s) begin
            streak_d = streak_q + STREAK_W'(1);
        end else begin
            streak_d = streak_q;
        end
    end

    // Registered SRAM command and swap permission for the next cycle.
    always_comb begin
        mem_en_d    = disp_gnt_s | rast_gnt_s;
        mem_we_d    = rast_gnt_s;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (disp_gnt_s) begin
            mem_addr_d = {buf_index(i_rasterization_target, 1'b1), i_disp_addr};
        end else if (rast_gnt_s) begin
            mem_addr_d  = {buf_index(i_rasterization_target, 1'b0), i_rast_addr};
            mem_wdata_d = i_rast_wdata;
        end else begin
            mem_addr_d  = mem_addr_q;
            mem_wdata_d = mem_wdata_q;
        end
        swap_d = i_vblank & ~i_disp_req & ~rd_pending_s;
    end

    // Arbiter state and output registers.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q     <= ARB_IDLE;
            streak_q    <= STREAK_W'(0);
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {(ADDR_W + 1){1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            swap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            swap_q      <= swap_d;
        end
    end

    fb_rd_valid_pipe #(
        .DEPTH (READ_LATENCY + 1)
    ) u_rd_valid_pipe (
        .i_clk     (i_clk),
        .i_srst    (i_srst),
        .i_issue   (disp_gnt_s),
        .o_valid   (rd_valid_s),
        .o_pending (rd_pending_s)
    );

    assign o_disp_gnt                  = disp_gnt_s;
    assign o_rast_gnt                  = rast_gnt_s;
    assign o_mem_en                    = mem_en_q;
    assign o_mem_we                    = mem_we_q;
    assign o_mem_addr                  = mem_addr_q;
    assign o_mem_wdata                 = mem_wdata_q;
    assign o_disp_rvalid               = rd_valid_s;
    assign o_disp_rdata                = rd_valid_s ? i_mem_rdata : {DATA_W{1'b0}};
    assign o_frame_buffer_swap_allowed = swap_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles the rasterizer waits.
    always_comb begin
        if (i_rast_req && !rast_gnt_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_rast_stall_count = stall_cnt_q;
`endif

endmodule
